// File: rtl/nand_rosc_pkg.sv
// Shared widths, state encoding and small helpers for the NAND ring-oscillator
// measurement sequencer.
package nand_rosc_pkg;

    localparam int COUNT_W = 32;
    localparam int SUM_W   = 36;
    localparam int REPS_W  = 4;
    localparam int STATE_W = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_CLEAR   = 4'd1;
    localparam state_t ST_START   = 4'd2;
    localparam state_t ST_RUN     = 4'd3;
    localparam state_t ST_STOP    = 4'd4;
    localparam state_t ST_SETTLE  = 4'd5;
    localparam state_t ST_CAPTURE = 4'd6;
    localparam state_t ST_ACCUM   = 4'd7;
    localparam state_t ST_DONE    = 4'd8;

    // A request for zero measurements still runs one.
    function automatic logic [REPS_W-1:0] reps_norm(input logic [REPS_W-1:0] reps);
        return (reps == '0) ? REPS_W'(1) : reps;
    endfunction

endpackage

// File: rtl/nand_rosc_meas_ctrl_if.sv
// Host-side command/result bundle of the measurement sequencer.
interface nand_rosc_meas_ctrl_if #(parameter int WIN_W = 24);
    import nand_rosc_pkg::*;

    // Handshake: a transfer happens on a clk edge where valid && ready; the
    // initiator holds valid and payload stable until that edge.
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [WIN_W-1:0]     cmd_window;
    logic [REPS_W-1:0]    cmd_reps;
    logic                 res_valid;
    logic                 res_ready;
    logic [SUM_W-1:0]     res_sum;
    logic [COUNT_W-1:0]   res_last;
    logic                 res_err;

    modport master (
        output cmd_valid, cmd_window, cmd_reps, res_ready,
        input  cmd_ready, res_valid, res_sum, res_last, res_err
    );

    modport slave (
        input  cmd_valid, cmd_window, cmd_reps, res_ready,
        output cmd_ready, res_valid, res_sum, res_last, res_err
    );

endinterface

// File: rtl/nand_rosc_meas_ctrl_count_sync.sv
// Brings the ring-oscillator timer count into the clk domain and decides when
// the sampled value is trustworthy (three identical samples) or has timed out.
module rosc_count_sync #(
    parameter int CAP_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q,
    output logic        stable,
    output logic        timeout
);

    localparam int TW = $clog2(CAP_MAX + 1);

    logic [31:0]   s1_q;
    logic [31:0]   s2_q;
    logic [31:0]   prev_q;
    logic          seen_eq_q;
    logic [TW-1:0] tcnt_q;

    // The synchronizer and history run continuously so the first capture
    // cycle already has a valid previous sample to compare against.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            seen_eq_q <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            if (!en) begin
                seen_eq_q <= 1'b0;
                tcnt_q    <= '0;
            end else begin
                seen_eq_q <= (s2_q == prev_q);
                tcnt_q    <= tcnt_q + 1'b1;
            end
        end
    end

    assign q       = s2_q;
    assign stable  = en && seen_eq_q && (s2_q == prev_q);
    assign timeout = en && !stable && (tcnt_q == TW'(CAP_MAX - 1));

endmodule

// File: rtl/nand_rosc_meas_ctrl.sv
// Measurement sequencer: clear/start/run/stop the rosc timer, capture its count
// across the clock boundary, repeat N times and return the sum to the host.
module nand_rosc_meas_ctrl
    import nand_rosc_pkg::*;
#(
    parameter int HOLD_CYC   = 4,
    parameter int SETTLE_CYC = 8,
    parameter int CAP_MAX    = 64,
    parameter int WIN_W      = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    nand_rosc_meas_ctrl_if.slave host,
    output logic                 tmr_clear,
    output logic                 tmr_start,
    output logic                 tmr_stop,
    input  logic [COUNT_W-1:0]   tmr_count,
    output logic                 busy,
    output state_t               dbg_state
);

    localparam logic [WIN_W-1:0] HOLD_LAST   = WIN_W'(HOLD_CYC - 1);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);

    state_t              state_q,  state_d;
    logic [WIN_W-1:0]    cnt_q,    cnt_d;
    logic [WIN_W-1:0]    window_q, window_d;
    logic [REPS_W-1:0]   reps_q,   reps_d;
    logic [SUM_W-1:0]    sum_q,    sum_d;
    logic [COUNT_W-1:0]  last_q,   last_d;
    logic [COUNT_W-1:0]  sample_q, sample_d;
    logic                err_q,    err_d;
    logic                clear_q, start_q, stop_q, cmd_ready_q, res_valid_q, busy_q;

    logic                cap_en;
    logic [COUNT_W-1:0]  sync_q;
    logic                sync_stable;
    logic                sync_timeout;

    assign cap_en = (state_q == ST_CAPTURE);

    rosc_count_sync #(.CAP_MAX(CAP_MAX)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .en      (cap_en),
        .d       (tmr_count),
        .q       (sync_q),
        .stable  (sync_stable),
        .timeout (sync_timeout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        window_d = window_q;
        reps_d   = reps_q;
        sum_d    = sum_q;
        last_d   = last_q;
        sample_d = sample_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (host.cmd_valid) begin
                    window_d = host.cmd_window;
                    reps_d   = reps_norm(host.cmd_reps);
                    sum_d    = '0;
                    err_d    = 1'b0;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: if (cnt_q == HOLD_LAST) begin
                cnt_d   = '0;
                state_d = ST_START;
            end
            ST_START: if (cnt_q == HOLD_LAST) begin
                cnt_d   = '0;
                state_d = (window_q == '0) ? ST_STOP : ST_RUN;
            end
            ST_RUN: if (cnt_q == window_q - 1'b1) begin
                cnt_d   = '0;
                state_d = ST_STOP;
            end
            ST_STOP: if (cnt_q == HOLD_LAST) begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: if (cnt_q == SETTLE_LAST) begin
                cnt_d   = '0;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                cnt_d = '0;
                if (sync_stable || sync_timeout) begin
                    sample_d = sync_q;
                    err_d    = err_q | sync_timeout;
                    state_d  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                cnt_d   = '0;
                sum_d   = sum_q + SUM_W'(sample_q);
                last_d  = sample_q;
                reps_d  = reps_q - 1'b1;
                state_d = (reps_q == REPS_W'(1)) ? ST_DONE : ST_CLEAR;
            end
            ST_DONE: begin
                cnt_d = '0;
                if (host.res_ready) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control outputs are registered copies of the next state, so they line up
    // with state_q and can never glitch or overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            window_q    <= '0;
            reps_q      <= '0;
            sum_q       <= '0;
            last_q      <= '0;
            sample_q    <= '0;
            err_q       <= 1'b0;
            clear_q     <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            window_q    <= window_d;
            reps_q      <= reps_d;
            sum_q       <= sum_d;
            last_q      <= last_d;
            sample_q    <= sample_d;
            err_q       <= err_d;
            clear_q     <= (state_d == ST_CLEAR);
            start_q     <= (state_d == ST_START);
            stop_q      <= (state_d == ST_STOP);
            cmd_ready_q <= (state_d == ST_IDLE);
            res_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign tmr_clear      = clear_q;
    assign tmr_start      = start_q;
    assign tmr_stop       = stop_q;
    assign busy           = busy_q;
    assign dbg_state      = state_q;
    assign host.cmd_ready = cmd_ready_q;
    assign host.res_valid = res_valid_q;
    assign host.res_sum   = sum_q;
    assign host.res_last  = last_q;
    assign host.res_err   = err_q;

endmodule

// File: tb/tb_nand_rosc_meas_ctrl.sv
// Directed bench for the rosc measurement sequencer with a simple timer model.
module tb_nand_rosc_meas_ctrl;
    import nand_rosc_pkg::*;

    logic               clk;
    logic               rst;
    logic               tmr_clear, tmr_start, tmr_stop, busy;
    logic [31:0]        tmr_count;
    state_t             dbg_state;

    nand_rosc_meas_ctrl_if #(.WIN_W(24)) hif ();

    nand_rosc_meas_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .host      (hif),
        .tmr_clear (tmr_clear),
        .tmr_start (tmr_start),
        .tmr_stop  (tmr_stop),
        .tmr_count (tmr_count),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // timer model: 0 = counts 5 per clk between start and stop,
    // 1 = table value per measurement, 2 = toggles every clk
    int          model_mode;
    int          tab_gen;
    logic [31:0] tab [0:15];
    int          tab_idx, seen_gen;
    logic        run_m, clear_prev_m;

    initial begin
        tmr_count    = '0;
        run_m        = 1'b0;
        clear_prev_m = 1'b0;
        tab_idx      = 0;
        seen_gen     = 0;
    end

    always @(posedge clk) begin
        clear_prev_m <= tmr_clear;
        if (tab_gen != seen_gen) begin
            seen_gen <= tab_gen;
            tab_idx  <= 0;
        end
        case (model_mode)
            0: begin
                if (tmr_clear) begin
                    tmr_count <= '0;
                    run_m     <= 1'b0;
                end else begin
                    if (tmr_start)     run_m <= 1'b1;
                    else if (tmr_stop) run_m <= 1'b0;
                    if (run_m) tmr_count <= tmr_count + 32'd5;
                end
            end
            1: if (tmr_clear && !clear_prev_m && tab_gen == seen_gen) begin
                tmr_count <= tab[tab_idx];
                tab_idx   <= tab_idx + 1;
            end
            default: tmr_count <= ~tmr_count;
        endcase
    end

    // monitor of the timer controls, sampled on the falling edge
    int   n_clear_pulses, n_overlap;
    int   cur_clear, cur_start, cur_stop, cur_gap, cur_cap;
    int   last_clear_len, last_start_len, last_stop_len, last_gap, last_cap;
    logic in_gap, prev_clear, prev_start, prev_stop, prev_cap;

    initial begin
        n_clear_pulses = 0; n_overlap = 0;
        cur_clear = 0; cur_start = 0; cur_stop = 0; cur_gap = 0; cur_cap = 0;
        last_clear_len = 0; last_start_len = 0; last_stop_len = 0; last_gap = -1; last_cap = 0;
        in_gap = 0; prev_clear = 0; prev_start = 0; prev_stop = 0; prev_cap = 0;
    end

    always @(negedge clk) begin
        if (32'(tmr_clear) + 32'(tmr_start) + 32'(tmr_stop) > 1) n_overlap++;
        if (tmr_clear && !prev_clear) n_clear_pulses++;
        if (tmr_clear) cur_clear++;
        else if (prev_clear) begin last_clear_len = cur_clear; cur_clear = 0; end
        if (tmr_start) cur_start++;
        else if (prev_start) begin last_start_len = cur_start; cur_start = 0; end
        if (tmr_stop) cur_stop++;
        else if (prev_stop) begin last_stop_len = cur_stop; cur_stop = 0; end
        if (tmr_start) begin in_gap = 1; cur_gap = 0; end
        else if (tmr_stop && in_gap) begin last_gap = cur_gap; in_gap = 0; end
        else if (in_gap && !tmr_clear) cur_gap++;
        if (tmr_clear) in_gap = 0;
        if (dbg_state == ST_CAPTURE) cur_cap++;
        else if (prev_cap) begin last_cap = cur_cap; cur_cap = 0; end
        prev_clear = tmr_clear;
        prev_start = tmr_start;
        prev_stop  = tmr_stop;
        prev_cap   = (dbg_state == ST_CAPTURE);
    end

    // scoreboard
    int          n_cmp, n_bad;
    logic [35:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [23:0] win, input logic [3:0] reps);
        int guard;
        guard = 0;
        while (!hif.cmd_ready && guard < 100) begin tick(); guard++; end
        hif.cmd_window = win;
        hif.cmd_reps   = reps;
        hif.cmd_valid  = 1'b1;
        tick();
        hif.cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int guard;
        guard = 0;
        while (!hif.res_valid && guard < 20000) begin tick(); guard++; end
        if (!hif.res_valid) check_eq({tag, "_timeout"}, 64'(hif.res_valid), 64'd1);
    endtask

    task automatic accept_result();
        hif.res_ready = 1'b1;
        tick();
        hif.res_ready = 1'b0;
    endtask

    task automatic check_sum(input string tag);
        logic [35:0] e;
        e = exp_q.pop_front();
        check_eq(tag, 64'(hif.res_sum), 64'(e));
    endtask

    int          pulses0;
    int          unstable;
    int          guard;

    initial begin
        n_cmp = 0; n_bad = 0;
        model_mode = 0; tab_gen = 0;
        hif.cmd_valid = 1'b0; hif.cmd_window = '0; hif.cmd_reps = '0; hif.res_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        check_eq("rst_ctrl",      64'({tmr_clear, tmr_start, tmr_stop}), 64'd0);
        check_eq("rst_cmd_ready", 64'(hif.cmd_ready), 64'd1);
        check_eq("rst_busy",      64'(busy), 64'd0);
        check_eq("rst_res_valid", 64'(hif.res_valid), 64'd0);
        check_eq("rst_res_sum",   64'(hif.res_sum), 64'd0);

        // reset in the middle of the gate window
        send_cmd(24'd200, 4'd1);
        guard = 0;
        while (dbg_state != ST_RUN && guard < 100) begin tick(); guard++; end
        check_eq("t1_reach_run", 64'(dbg_state), 64'(ST_RUN));
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check_eq("t1_ctrl",      64'({tmr_clear, tmr_start, tmr_stop}), 64'd0);
        check_eq("t1_busy",      64'(busy), 64'd0);
        check_eq("t1_cmd_ready", 64'(hif.cmd_ready), 64'd1);
        check_eq("t1_res_valid", 64'(hif.res_valid), 64'd0);
        rst = 1'b0;
        tick();

        // single measurement with the counting model: 4 start + 100 run edges
        pulses0 = n_clear_pulses;
        exp_q.push_back(36'd520);
        send_cmd(24'd100, 4'd1);
        wait_done("t2");
        check_sum("t2_sum");
        check_eq("t2_last",      64'(hif.res_last), 64'd520);
        check_eq("t2_err",       64'(hif.res_err), 64'd0);
        check_eq("t2_clear_len", 64'(last_clear_len), 64'd4);
        check_eq("t2_start_len", 64'(last_start_len), 64'd4);
        check_eq("t2_stop_len",  64'(last_stop_len), 64'd4);
        check_eq("t2_gap",       64'(last_gap), 64'd100);
        check_eq("t2_pulses",    64'(n_clear_pulses - pulses0), 64'd1);
        accept_result();

        // three measurements from a table
        model_mode = 1;
        tab[0] = 32'd1000; tab[1] = 32'd1002; tab[2] = 32'd999;
        tab_gen++;
        tick();
        pulses0 = n_clear_pulses;
        exp_q.push_back(36'd3001);
        send_cmd(24'd10, 4'd3);
        wait_done("t3");
        check_sum("t3_sum");
        check_eq("t3_last",   64'(hif.res_last), 64'd999);
        check_eq("t3_err",    64'(hif.res_err), 64'd0);
        check_eq("t3_pulses", 64'(n_clear_pulses - pulses0), 64'd3);
        accept_result();

        // count never settles: capture times out
        model_mode = 2;
        pulses0 = n_clear_pulses;
        send_cmd(24'd5, 4'd1);
        wait_done("t4");
        check_eq("t4_err",       64'(hif.res_err), 64'd1);
        check_eq("t4_cap_cycles", 64'(last_cap), 64'd64);
        check_eq("t4_pulses",    64'(n_clear_pulses - pulses0), 64'd1);
        accept_result();

        // backpressure with a command knocking while the result waits
        model_mode = 1;
        tab[0] = 32'h1234;
        tab_gen++;
        tick();
        pulses0 = n_clear_pulses;
        send_cmd(24'd3, 4'd1);
        wait_done("t5");
        unstable = 0;
        hif.cmd_valid = 1'b1;
        hif.cmd_window = 24'd1;
        hif.cmd_reps = 4'd2;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hif.res_sum !== 36'h1234 || hif.res_last !== 32'h1234 ||
                hif.res_err !== 1'b0 || hif.res_valid !== 1'b1 || hif.cmd_ready !== 1'b0)
                unstable++;
        end
        hif.cmd_valid = 1'b0;
        check_eq("t5_stable",    64'(unstable), 64'd0);
        check_eq("t5_state",     64'(dbg_state), 64'(ST_DONE));
        accept_result();
        check_eq("t5_cmd_ready", 64'(hif.cmd_ready), 64'd1);
        check_eq("t5_res_valid", 64'(hif.res_valid), 64'd0);
        check_eq("t5_hold_sum",  64'(hif.res_sum), 64'h1234);
        check_eq("t5_pulses",    64'(n_clear_pulses - pulses0), 64'd1);

        // reps=0 and window=0: one measurement with no gate window
        tab[0] = 32'd77;
        tab_gen++;
        tick();
        pulses0 = n_clear_pulses;
        exp_q.push_back(36'd77);
        send_cmd(24'd0, 4'd0);
        wait_done("t6a");
        check_sum("t6a_sum");
        check_eq("t6a_gap",    64'(last_gap), 64'd0);
        check_eq("t6a_pulses", 64'(n_clear_pulses - pulses0), 64'd1);
        accept_result();

        // fifteen full-scale counts
        for (int i = 0; i < 16; i++) tab[i] = 32'hFFFF_FFFF;
        tab_gen++;
        tick();
        pulses0 = n_clear_pulses;
        exp_q.push_back(36'hE_FFFF_FFF1);
        send_cmd(24'd2, 4'd15);
        wait_done("t6b");
        check_sum("t6b_sum");
        check_eq("t6b_last",   64'(hif.res_last), 64'hFFFF_FFFF);
        check_eq("t6b_pulses", 64'(n_clear_pulses - pulses0), 64'd15);
        accept_result();

        check_eq("ctrl_overlap", 64'(n_overlap), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nand_rosc_meas_ctrl.md
Name: nand_rosc_meas_ctrl

Overview:
Measurement sequencer for the NAND ring-oscillator timer, running on the system clock. On a host command it drives the timer's clear/start/stop controls with fixed hold times, runs a programmable gate window, and captures the timer's elapsed count across the clock-domain boundary. It repeats this for N measurements and returns the sum through a valid/ready result interface. It sits between the host/register interface and the timer instance.

Parameters:
HOLD_CYC, 4, clk cycles each of tmr_clear/tmr_start/tmr_stop is held high (must cover ≥2 slowest rosc periods)
SETTLE_CYC, 8, clk cycles of idle after stop deasserts before capture begins
CAP_MAX, 64, max clk cycles in CAPTURE before timeout
WIN_W, 24, width of gate-window length field

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_window  in  WIN_W  gate window length in clk cycles
cmd_reps  in  4  measurement count; 0 treated as 1
tmr_clear  out  1  to timer clear
tmr_start  out  1  to timer start
tmr_stop  out  1  to timer stop
tmr_count  in  32  timer elapsed_count (rosc domain, asynchronous to clk)
res_valid  out  1  result available
res_ready  in  1  result accepted
res_sum  out  36  sum of captured counts
res_last  out  32  last captured count
res_err  out  1  at least one capture timed out in this command
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst high at a clk edge): state IDLE. All outputs 0 except cmd_ready=1. sum, rep counter, and err cleared. Reset mid-sequence drops the timer controls low on the next edge. The timer's count is not otherwise touched.
- Command accept: cmd_valid&&cmd_ready latches window and reps (0→1), clears sum/err, and moves to CLEAR.
- States and transitions:
  - CLEAR: tmr_clear=1 for HOLD_CYC cycles, then START.
  - START: tmr_start=1 for HOLD_CYC cycles, then RUN.
  - RUN: all timer controls 0 for window cycles, then STOP. window=0 means zero RUN cycles, so STOP follows START directly.
  - STOP: tmr_stop=1 for HOLD_CYC cycles, then SETTLE.
  - SETTLE: SETTLE_CYC cycles, then CAPTURE.
  - CAPTURE: see capture rule below.
  - ACCUM: one cycle; sum += sample, res_last = sample, rep decrements. If more reps remain → CLEAR, else → DONE.
  - DONE: res_valid=1. On res_ready → IDLE; cmd_ready is 1 on the next cycle.
- Control invariant: at most one of tmr_clear/tmr_start/tmr_stop is high in any cycle. All three are registered outputs; there are no combinational paths from inputs to outputs.
- Capture rule:
  - tmr_count passes through a 2-flop synchronizer every cycle.
  - Sample is accepted when the synchronized value equals the previous synchronized value on 2 consecutive cycles (3 identical samples).
  - If not accepted within CAP_MAX cycles, the current synchronized value is taken, err is set sticky for the command, and the sequence proceeds to ACCUM.
- Width rule: sum is 36-bit unsigned, zero-extended add; 16×(2^32−1) fits, so no saturation is needed.
- Result stability: res_sum/res_last/res_err are held stable while res_valid=1 and res_ready=0. Outputs keep their values after the handshake until the next command accept.
- cmd_valid outside IDLE is ignored (not queued).

Decomposition:
- Package nand_rosc_pkg: state enum (IDLE, CLEAR, START, RUN, STOP, SETTLE, CAPTURE, ACCUM, DONE), COUNT_W=32, SUM_W=36, REPS_W=4.
- Sub-module rosc_count_sync: 2-flop synchronizer plus equality/stability detector and CAP_MAX timeout counter.
  - Interfaces: clk, rst, en, d[31:0], q[31:0], stable, timeout.
  - Controller FSM and accumulator stay in the top.

Test Plan:
1. Reset mid-RUN (rst=1 one cycle) → next cycle all tmr_* 0, busy 0, cmd_ready 1, res_valid 0.
2. Single measurement, window=100, reps=1, timer model counts 5 per clk while measuring → tmr_clear/start/stop each high exactly 4 cycles, start→stop gap 100 cycles; res_sum equals latched model count (≈5×(100+4)); res_err 0.
3. reps=3, model returns 1000/1002/999 → three full CLEAR…ACCUM passes; res_sum=3001, res_last=999.
4. Unstable tmr_count (toggles every cycle) → CAPTURE exits after 64 cycles, res_err=1, sequence completes.
5. Backpressure: res_ready held 0 for 20 cycles with res_sum=0x0_0000_1234 → outputs stable and cmd_valid ignored. Raising res_ready → IDLE; cmd_ready=1 next cycle.
6. Edge cases: reps=0, window=0 → exactly one measurement with no RUN cycles. reps=15 with count 0xFFFF_FFFF each → res_sum=0xE_FFFF_FFF1.
